// File: rtl/nwr_req_arbiter_pkg.sv
// Shared types and widths for the SRIO NWRITE user-channel arbiter.
package nwr_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_DONE = 2'd2
  } nwr_state_e;

  localparam int ADDR_W = 34;
  localparam int SIZE_W = 20;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

endpackage

// File: rtl/nwr_req_arbiter_if.sv
// Engine-side bus between the arbiter (master) and the NWRITE initiator engine (slave).
interface nwr_req_arbiter_if;
  import nwr_req_arbiter_pkg::*;

  logic              nwr_ready_in;
  logic              nwr_busy_in;
  logic              nwr_done_in;
  logic              user_tready_in;
  logic [ADDR_W-1:0] user_addr_o;
  logic [SIZE_W-1:0] user_tsize_o;
  logic [DATA_W-1:0] user_tdata_o;
  logic [KEEP_W-1:0] user_tkeep_o;
  logic              user_tvalid_o;
  logic              user_tfirst_o;
  logic              user_tlast_o;

  modport master (
    input  nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    output user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
           user_tvalid_o, user_tfirst_o, user_tlast_o
  );

  modport slave (
    output nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    input  user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
           user_tvalid_o, user_tfirst_o, user_tlast_o
  );

endinterface

// File: rtl/nwr_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_vld
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one extra bit so ptr+i can be wrapped without losing the carry
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!pick_vld && req[idx]) begin
        pick_vld      = 1'b1;
        pick_idx      = idx;
        pick[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nwr_req_arbiter.sv
// Round-robin arbiter sharing one NWRITE user channel among NUM_REQ packet sources;
// ownership moves only after a packet's tlast and the engine's done (or a timeout).
module nwr_req_arbiter
  import nwr_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DONE_TMO = 1024
) (
  input  logic                      log_clk,
  input  logic                      log_rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*SIZE_W-1:0] req_tsize_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_tdata_i,
  input  logic [NUM_REQ*KEEP_W-1:0] req_tkeep_i,
  input  logic [NUM_REQ-1:0]        req_tvalid_i,
  input  logic [NUM_REQ-1:0]        req_tlast_i,
  output logic [NUM_REQ-1:0]        req_tready_o,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      tmo_err_o,
  nwr_req_arbiter_if.master         eng
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(DONE_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [SIZE_W-1:0] tsize_a [NUM_REQ];
  logic [DATA_W-1:0] tdata_a [NUM_REQ];
  logic [KEEP_W-1:0] tkeep_a [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign addr_a[k]  = req_addr_i [k*ADDR_W +: ADDR_W];
    assign tsize_a[k] = req_tsize_i[k*SIZE_W +: SIZE_W];
    assign tdata_a[k] = req_tdata_i[k*DATA_W +: DATA_W];
    assign tkeep_a[k] = req_tkeep_i[k*KEEP_W +: KEEP_W];
  end

  nwr_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  logic             first_flag;
  logic [TMO_W-1:0] tmo_cnt;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req_i),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  logic             xfer;
  logic             start;
  logic             beat_acc;
  logic             release_now;
  logic [PTR_W-1:0] next_ptr;

  assign xfer        = (state == XFER);
  assign start       = (state == IDLE) && pick_vld && eng.nwr_ready_in && !eng.nwr_busy_in;
  assign beat_acc    = xfer && req_tvalid_i[gidx] && eng.user_tready_in;
  assign release_now = (state == WAIT_DONE) && (eng.nwr_done_in || (tmo_cnt == TMO_LAST));
  assign next_ptr    = (gidx == PTR_LAST) ? '0 : gidx + PTR_W'(1);

  // Beat path is a pure mux of the granted slot, forced quiet outside XFER.
  always_comb begin
    eng.user_tdata_o  = '0;
    eng.user_tkeep_o  = '0;
    eng.user_tvalid_o = 1'b0;
    eng.user_tlast_o  = 1'b0;
    eng.user_tfirst_o = 1'b0;
    req_tready_o      = '0;
    if (xfer) begin
      eng.user_tdata_o   = tdata_a[gidx];
      eng.user_tkeep_o   = tkeep_a[gidx];
      eng.user_tvalid_o  = req_tvalid_i[gidx];
      eng.user_tlast_o   = req_tlast_i[gidx];
      eng.user_tfirst_o  = first_flag;
      req_tready_o[gidx] = eng.user_tready_in;
    end
  end

  always_ff @(posedge log_clk) begin
    if (!log_rst_n) begin
      state            <= IDLE;
      gnt_o            <= '0;
      gidx             <= '0;
      rr_ptr           <= '0;
      first_flag       <= 1'b1;
      tmo_cnt          <= '0;
      tmo_err_o        <= 1'b0;
      eng.user_addr_o  <= '0;
      eng.user_tsize_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gnt_o            <= pick;
            gidx             <= pick_idx;
            eng.user_addr_o  <= addr_a[pick_idx];
            eng.user_tsize_o <= tsize_a[pick_idx];
            state            <= XFER;
          end
        end
        XFER: begin
          // done pulses here are deliberately ignored; only tlast ends the burst
          if (beat_acc) begin
            first_flag <= 1'b0;
            if (req_tlast_i[gidx]) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (release_now) begin
            state      <= IDLE;
            gnt_o      <= '0;
            rr_ptr     <= next_ptr;
            first_flag <= 1'b1;
            tmo_cnt    <= '0;
            if (!eng.nwr_done_in) tmo_err_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
